// File: rtl/logic_pipe_i8.sv
// -----------------------------------------------------------------------------
// logic_pipe_i8
//
// Pipelined bitwise logic unit with a valid/ready handshake on both sides.
// A request (op, a, b) is evaluated combinationally at accept time. The result
// then travels through STAGES registered stages, each of which has a valid bit.
// The last stage drives y/out_valid. A sticky OR-accumulator (op 7) is updated
// on the same edge that accepts the request, so back-to-back op 7 requests
// chain. Full throughput is one result per cycle, and bubbles collapse.
//
// Parameters
//   WIDTH   operand/result width in bits
//   STAGES  number of pipeline registers between accept and out_valid (1..4)
//
// Ports
//   clock      in   clock, all state updates on posedge
//   reset      in   synchronous, active-high; discards in-flight results
//   in_valid   in   request present
//   in_ready   out  unit can accept a request this cycle (depends on out_ready)
//   op         in   operation select, sampled together with a/b at accept
//   a, b       in   operands
//   out_valid  out  y holds a result
//   out_ready  in   consumer takes y this cycle
//   y          out  result (holds its last value while out_valid=0)
//   acc        out  registered accumulator value
// -----------------------------------------------------------------------------
module logic_pipe_i8 #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_ANDN  = 3'd6;
    localparam logic [2:0] OP_ACCOR = 3'd7;

    // Stage 0 is the accept register; stage STAGES-1 drives the outputs.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];

    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;

    // load[i]: stage i takes its predecessor's contents at the next edge
    logic [STAGES-1:0] load;
    logic              accept;
    logic [WIDTH-1:0]  acc_or;
    logic [WIDTH-1:0]  result;

    // A stage may load when it is empty or when its own contents move on.
    // Unrolled from the output backwards, that is: the consumer takes y, or
    // there is an empty slot at or after this stage. Building it from a
    // running "hole seen" flag keeps the chain free of self-referencing bits.
    always_comb begin : load_chain
        logic hole;
        hole = 1'b0;
        load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hole    = hole | ~valid_q[i];
            load[i] = out_ready | hole;
        end
    end

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign in_ready = load[0];
    assign accept   = in_valid & in_ready;

    // The accumulator value that an accepted op 7 produces. It is shared by
    // the result path and the acc update so that both always agree.
    assign acc_or = acc_q | a | b;

    always_comb begin
        result = '0;
        case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NAND:  result = ~(a & b);
            OP_NOR:   result = ~(a | b);
            OP_XNOR:  result = ~(a ^ b);
            OP_ANDN:  result = a & ~b;
            OP_ACCOR: result = acc_or;
            default:  result = '0;
        endcase
    end

    // acc moves only on an accepted op 7; stalls and deliveries leave it alone.
    always_comb begin
        acc_d = acc_q;
        if (accept && (op == OP_ACCOR)) begin
            acc_d = acc_or;
        end
    end

    // Stage next-state. Data registers only update when real data arrives, so
    // y keeps its last value once the pipe drains.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = data_q[i];
        end

        if (load[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = result;
            end
        end

        for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            acc_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            acc_q   <= acc_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign y         = data_q[STAGES-1];
    assign acc       = acc_q;

endmodule

// File: tb/tb_logic_pipe_i8.sv
// -----------------------------------------------------------------------------
// tb_logic_pipe_i8
//
// Scoreboard bench for logic_pipe_i8. The stimulus process drives requests.
// On every accept it computes the expected result from per-op truth tables
// and pushes it into a queue. The monitor process owns out_ready and pops and
// compares on every delivery. It also checks that y and out_valid hold while
// the output is stalled.
// -----------------------------------------------------------------------------
module tb_logic_pipe_i8;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] acc;

    always #5 clock = ~clock;

    logic_pipe_i8 #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .acc       (acc)
    );

    int         tests     = 0;
    int         fails     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_acc = '0;
    int         rdy_mode  = 1;   // 0: out_ready=1, 1: out_ready=0, 2: random
    int         n_acc     = 0;
    int         n_del     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Each op is defined by its 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [3:0] truth_table(input logic [2:0] o);
        case (o)
            3'd0:    return 4'b1000;  // AND
            3'd1:    return 4'b1110;  // OR
            3'd2:    return 4'b0110;  // XOR
            3'd3:    return 4'b0111;  // NAND
            3'd4:    return 4'b0001;  // NOR
            3'd5:    return 4'b1001;  // XNOR
            3'd6:    return 4'b0100;  // ANDN
            default: return 4'b1110;  // ACCOR: a|b, then folded into acc
        endcase
    endfunction

    task automatic model_issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        logic [3:0] tt;
        logic [7:0] r;
        tt = truth_table(o);
        for (int i = 0; i < 8; i++) begin
            r[i] = tt[{x[i], z[i]}];
        end
        if (o == 3'd7) begin
            model_acc = model_acc | r;
            r = model_acc;
        end
        exp_q.push_back(r);
        n_acc++;
    endtask

    // One stimulus cycle. The request is sampled at the posedge following return.
    task automatic drive_cycle(input logic v, input logic [2:0] o, input logic [7:0] x,
                               input logic [7:0] z, output logic took);
        @(negedge clock);
        #1;
        check("acc", acc, model_acc);
        in_valid = v;
        op       = o;
        a        = x;
        b        = z;
        #2;
        took = v && in_ready;
        if (took) begin
            model_issue(o, x, z);
        end
    endtask

    task automatic drain(input int n, input string name);
        logic took;
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, 3'd0, 8'h00, 8'h00, took);
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
        reset     = 1'b0;
        exp_q.delete();
        model_acc = '0;
        n_acc     = n_del;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_y", y, 8'h00);
        check("reset_acc", acc, 8'h00);
        check("reset_in_ready", in_ready, 1'b1);
    endtask

    // Consumer side: owns out_ready, pops and compares on every delivery.
    initial begin : monitor
        logic       prev_stall;
        logic [7:0] prev_y;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_y     = '0;
        out_ready  = 1'b0;
        forever begin
            @(negedge clock);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #2;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", out_valid, 1'b1);
                    check("stall_hold_y", y, prev_y);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_output", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        n_del++;
                        $display("[TB] deliver %0d y=%02h exp=%02h", n_del, y, e);
                        check("y", y, e);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_y     = y;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic       took;
        logic [2:0] o;
        logic [7:0] x;
        logic [7:0] z;
        int         accepts;

        // Reset state
        rdy_mode = 1;
        do_reset(2);

        // Single OR request and its latency
        rdy_mode = 0;
        drive_cycle(1'b1, 3'd1, 8'd3, 8'd8, took);
        check("t1_accept", took, 1'b1);
        for (int k = 1; k <= STAGES; k++) begin
            drive_cycle(1'b0, 3'd0, 8'h00, 8'h00, took);
            check($sformatf("t1_out_valid_c%0d", k), out_valid, (k == STAGES));
        end
        drain(STAGES + 2, "t1_drain");

        // Ops 0..6 back-to-back at full rate
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1'b1, 3'(i), 8'hF0, 8'h3C, took);
            check($sformatf("t2_in_ready_op%0d", i), took, 1'b1);
        end
        drain(STAGES + 2, "t2_drain");

        // Accumulator chaining, then a non-accumulating op
        drive_cycle(1'b1, 3'd7, 8'h01, 8'h02, took);
        check("t3_accept0", took, 1'b1);
        drive_cycle(1'b1, 3'd7, 8'h80, 8'h00, took);
        check("t3_accept1", took, 1'b1);
        drive_cycle(1'b1, 3'd1, 8'h00, 8'h00, took);
        check("t3_accept2", took, 1'b1);
        drain(STAGES + 2, "t3_drain");
        check("t3_acc", acc, 8'h83);

        // Backpressure: exactly STAGES accepts, then in_ready drops
        rdy_mode = 1;
        accepts  = 0;
        o = 3'($urandom_range(0, 6));
        x = 8'($urandom);
        z = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, o, x, z, took);
            if (took) begin
                accepts++;
                o = 3'($urandom_range(0, 6));
                x = 8'($urandom);
                z = 8'($urandom);
            end
        end
        check("t4_accepts", 32'(accepts), 32'(STAGES));
        check("t4_in_ready_low", in_ready, 1'b0);
        rdy_mode = 0;
        drain(STAGES + 3, "t4_drain");

        // Reset with results in flight and acc=83
        rdy_mode = 1;
        drive_cycle(1'b1, 3'd0, 8'hAA, 8'hFF, took);
        check("t5_accept0", took, 1'b1);
        drive_cycle(1'b1, 3'd2, 8'h12, 8'h34, took);
        check("t5_accept1", took, 1'b1);
        do_reset(1);
        rdy_mode = 0;
        drive_cycle(1'b1, 3'd2, 8'h55, 8'h0F, took);
        check("t5_accept_post", took, 1'b1);
        drain(STAGES + 3, "t5_drain");
        check("t5_count", 32'(n_del), 32'(n_acc));

        // Random traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        8'($urandom), 8'($urandom), took);
        end
        rdy_mode = 0;
        drain(STAGES + 4, "t6_drain");
        check("t6_count", 32'(n_del), 32'(n_acc));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
